// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO register, enqueue side and dequeue controller.
//   DEF_RANK_WIDTH / DEF_META_WIDTH : default payload field widths
//   COUNTER_WIDTH                   : width of the optional statistics counters
//   deq_state_t                     : dequeue controller FSM states
package pifo_pkg;

    localparam int unsigned DEF_RANK_WIDTH = 8;
    localparam int unsigned DEF_META_WIDTH = 8;
    localparam int unsigned COUNTER_WIDTH  = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } deq_state_t;

endpackage

// File: rtl/pifo_deq_out_reg.sv
// Single-entry valid/ready holding register.
//   clk, rst              : clock, synchronous active-high reset
//   load                  : capture load_rank/load_meta and set valid (wins over transfer)
//   load_rank, load_meta  : entry to capture
//   ready                 : downstream ready; valid && ready is a transfer
//   valid, rank, meta     : held entry presented downstream
// The caller must only assert load when the slot is free (!valid || ready),
// so a load in a transfer cycle refills the slot with no bubble.
module pifo_deq_out_reg #(
    parameter int unsigned RANK_WIDTH = 8,
    parameter int unsigned META_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [RANK_WIDTH-1:0] load_rank,
    input  logic [META_WIDTH-1:0] load_meta,
    input  logic                  ready,
    output logic                  valid,
    output logic [RANK_WIDTH-1:0] rank,
    output logic [META_WIDTH-1:0] meta
);

    // Data only changes on load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            rank  <= '0;
            meta  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            rank  <= load_rank;
            meta  <= load_meta;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pifo_deq_ctrl.sv
// Dequeue controller for the PIFO register: pops the min entry into a
// one-entry output register and waits SETTLE_CYCLES after each remove so the
// PIFO can recompute its min before pifo_valid is trusted again.
//   clk, rst                          : clock, synchronous active-high reset
//   deq_en                            : 0 pauses popping (handshake still completes)
//   pifo_valid/rank/meta/empty        : PIFO min-entry view
//   pifo_remove                       : Mealy remove pulse, same cycle as the sampled data
//   out_valid/rank/meta, out_ready    : valid/ready egress interface
//   busy                              : high while settling
// Optional feature macro PIFO_DEQ_STATS_EN adds saturating deq_count and
// stall_count outputs.
module pifo_deq_ctrl
    import pifo_pkg::*;
#(
    parameter int unsigned RANK_WIDTH    = pifo_pkg::DEF_RANK_WIDTH,
    parameter int unsigned META_WIDTH    = pifo_pkg::DEF_META_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     deq_en,
    input  logic                     pifo_valid,
    input  logic [RANK_WIDTH-1:0]    pifo_rank,
    input  logic [META_WIDTH-1:0]    pifo_meta,
    input  logic                     pifo_empty,
    output logic                     pifo_remove,
    output logic                     out_valid,
    output logic [RANK_WIDTH-1:0]    out_rank,
    output logic [META_WIDTH-1:0]    out_meta,
    input  logic                     out_ready,
    output logic                     busy
`ifdef PIFO_DEQ_STATS_EN
    ,
    output logic [COUNTER_WIDTH-1:0] deq_count,
    output logic [COUNTER_WIDTH-1:0] stall_count
`endif
);

    localparam int unsigned CNT_W = 4;

    deq_state_t       state;
    deq_state_t       state_next;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] settle_cnt_next;
    logic             slot_free;
    logic             pop;

    // State register, settle counter and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            busy       <= (state_next == SETTLE);
        end
    end

    // Next-state: a pop starts the settle window; it ends after the counter reaches 0.
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next      = SETTLE;
                    settle_cnt_next = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    settle_cnt_next = settle_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next      = IDLE;
                settle_cnt_next = '0;
            end
        endcase
    end

    // Outputs: remove is Mealy so the PIFO entry sampled is the one removed.
    always_comb begin
        slot_free   = !out_valid || out_ready;
        pop         = (state == IDLE) && !rst && deq_en && pifo_valid
                      && !pifo_empty && slot_free;
        pifo_remove = pop;
    end

    pifo_deq_out_reg #(
        .RANK_WIDTH (RANK_WIDTH),
        .META_WIDTH (META_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (pop),
        .load_rank (pifo_rank),
        .load_meta (pifo_meta),
        .ready     (out_ready),
        .valid     (out_valid),
        .rank      (out_rank),
        .meta      (out_meta)
    );

`ifdef PIFO_DEQ_STATS_EN
    // Saturating pop and output-stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            deq_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop && (deq_count != '1)) begin
                deq_count <= deq_count + COUNTER_WIDTH'(1);
            end
            if (out_valid && !out_ready && (stall_count != '1)) begin
                stall_count <= stall_count + COUNTER_WIDTH'(1);
            end
        end
    end
`endif

endmodule
